mac_accum_param: RTL
====================

Name: mac_accum_param

Overview:
- Parametrised multiply-accumulate unit for CNN layer-2 convolution windows; next generation of the fixed 8-bit, 16-tap layer-2 MAC.
- Streams TAP_COUNT (view, filter) pairs through a valid/ready handshake.
- Accumulates the scaled products with a selectable saturate or wrap policy.
- Presents the window result through an output valid/ready handshake to the layer-2 controller.
- Every accepted tap is counted; there is no dead first cycle.

Parameters:
DATA_W, 8, width of view_in and filter_in (unsigned)
ACC_W, 12, accumulator and result width
TAP_COUNT, 16, number of products per window (>=1)
FRAC_SHIFT, 8, right shift applied to each product before accumulation (0..2*DATA_W-1)
SATURATE, 1, 1 = clamp accumulator at 2^ACC_W-1; 0 = modulo-2^ACC_W wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a new window
abort  in  1  synchronous cancel of the current window
in_valid  in  1  view_in/filter_in carry a tap
in_ready  out  1  unit accepts a tap this cycle
view_in  in  DATA_W  activation sample
filter_in  in  DATA_W  weight sample
out_valid  out  1  out_data holds the finished window result
out_ready  in  1  consumer takes the result
out_data  out  ACC_W  accumulated result
out_sat  out  1  saturation occurred during this window (SATURATE=1 only; else 0)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; accumulator=0; tap counter=0.
  - out_valid=0, out_data=0, out_sat=0, in_ready=0, busy=0.
  - Release is synchronous to clk.
- States: IDLE, ACCUM, HOLD. Tap counter width is $clog2(TAP_COUNT+1).
- IDLE:
  - in_ready=0.
  - start=1 -> ACCUM; accumulator, counter and sticky saturation flag are cleared.
  - abort in IDLE has no effect.
- ACCUM:
  - in_ready=1. A tap is accepted when in_valid&&in_ready.
  - term = (view_in*filter_in) >> FRAC_SHIFT. The product is full 2*DATA_W wide and unsigned; term is zero-extended or truncated to ACC_W+1 before the add.
  - SATURATE=1: if acc+term > 2^ACC_W-1, the accumulator becomes 2^ACC_W-1 and the sticky flag is set.
  - SATURATE=0: acc = (acc+term) mod 2^ACC_W.
  - Cycles with in_valid=0 leave the accumulator and counter unchanged.
  - start in ACCUM is ignored.
  - On acceptance of the TAP_COUNT-th tap, the next state is HOLD.
- Output timing:
  - The cycle after the last tap is accepted, out_valid=1 and out_data=final accumulator.
  - out_sat=sticky flag.
  - Latency is 1 cycle from the last accepted tap to out_valid.
- HOLD:
  - in_ready=0.
  - out_valid, out_data and out_sat are held stable until out_ready=1.
  - On out_ready=1, out_valid drops next cycle and the state goes to IDLE.
  - If start=1 in the same cycle as out_ready=1, the state goes directly to ACCUM with cleared accumulator and counter (back-to-back windows, no idle bubble).
  - start without out_ready in HOLD is ignored.
- abort=1 in ACCUM or HOLD:
  - Next cycle: state=IDLE, out_valid=0, accumulator and counter cleared.
  - A tap presented in the abort cycle is discarded.
  - abort has priority over start, tap acceptance and out_ready.
- out_data keeps the last delivered value after HOLD exits; it is reset to 0 only by rst.
- Reset mid-window: immediate return to the reset values; no partial result is ever flagged valid.
- TAP_COUNT=1: a single accepted tap moves ACCUM->HOLD.

Test Plan:
- Defaults. start, then 16 taps view=16, filter=16 on consecutive cycles (term=1) -> out_valid one cycle after the 16th tap, out_data=16, out_sat=0. Hold out_ready=0 for 5 cycles -> output stable. Then out_ready=1 -> out_valid=0 next cycle, busy=0.
- Bubbles. Defaults; 16 taps view=255, filter=255 (term=254) with in_valid deasserted every other cycle -> exactly 16 taps counted, out_data=4064, out_sat=0.
- Saturate vs wrap. TAP_COUNT=17, 17 taps of 255x255:
  - SATURATE=1 -> out_data=4095, out_sat=1.
  - SATURATE=0 -> out_data=222, out_sat=0.
- Back-to-back windows:
  - Window 1: 16 taps 16x16. Assert out_ready and start in the same HOLD cycle -> state ACCUM next cycle.
  - Window 2: 16 taps of view=32, filter=8 -> second out_data=16, no accumulation carry-over from window 1.
- Abort and start priority:
  - After 7 taps, abort=1 together with in_valid=1 -> IDLE next cycle, out_valid never asserts.
  - start=1 in IDLE is honoured; start=1 in ACCUM is ignored.
  - A new full 16x16 window -> out_data=16.
- Async reset: drop rst mid-ACCUM between clock edges -> all outputs 0 immediately, without waiting for a clk edge. After release, start plus a full window -> correct result 16.

Source files
------------

// File: rtl/mac_accum_param.sv
// Parametrised multiply-accumulate unit for convolution windows.
// Streams TAP_COUNT (view, filter) pairs, accumulates the scaled products
// with a saturate or wrap policy, and hands the window result to the
// consumer through a valid/ready handshake that is held until taken.
module mac_accum_param #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 12,
    parameter int TAP_COUNT  = 16,
    parameter int FRAC_SHIFT = 8,
    parameter bit SATURATE   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] view_in,
    input  logic [DATA_W-1:0] filter_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int TERM_W = ACC_W + 1;
    localparam int SUM_W  = ACC_W + 2;
    localparam int CNT_W  = $clog2(TAP_COUNT + 1);

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAP_COUNT - 1);
    localparam logic [ACC_W-1:0] ACC_FULL = {ACC_W{1'b1}};
    localparam logic [SUM_W-1:0] ACC_MAX  = {2'b00, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sat_reg, sat_next;
    logic               out_valid_reg, out_valid_next;
    logic [ACC_W-1:0]   out_data_reg, out_data_next;
    logic               out_sat_reg, out_sat_next;

    logic [PROD_W-1:0]  prod;
    logic [TERM_W-1:0]  term;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_sum;
    logic               sat_hit;
    logic               unused_bits;

    // Full-width unsigned product of the current tap.
    assign prod = PROD_W'(view_in) * PROD_W'(filter_in);

    // Scaled term: product shifted right by FRAC_SHIFT, then zero-extended
    // or truncated to ACC_W+1 bits. Bits shifted past the top read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < TERM_W; gi++) begin : g_term
            if (gi + FRAC_SHIFT < PROD_W) begin : g_bit
                assign term[gi] = prod[gi + FRAC_SHIFT];
            end else begin : g_zero
                assign term[gi] = 1'b0;
            end
        end
    endgenerate

    // Two guard bits so the sum of a full accumulator and a full term never overflows.
    assign sum = {2'b00, acc_reg} + {1'b0, term};

    // Low product bits dropped by the shift and the sum guard bits in wrap mode
    // are intentionally discarded.
    assign unused_bits = ^{prod, sum};

    // Apply the overflow policy: clamp and flag, or keep the low ACC_W bits.
    always_comb begin
        acc_sum = sum[ACC_W-1:0];
        sat_hit = 1'b0;
        if (SATURATE && (sum > ACC_MAX)) begin
            acc_sum = ACC_FULL;
            sat_hit = 1'b1;
        end
    end

    // Window sequencing: next state, accumulator, tap counter and output register.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        sat_next       = sat_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sat_next   = out_sat_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end

            ACCUM: begin
                if (abort) begin
                    // Cancel wins over any tap presented in the same cycle.
                    state_next     = IDLE;
                    acc_next       = '0;
                    cnt_next       = '0;
                    sat_next       = 1'b0;
                    out_valid_next = 1'b0;
                end else if (in_valid) begin
                    acc_next = acc_sum;
                    sat_next = sat_reg | sat_hit;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_TAP) begin
                        // Final tap: publish the result straight from the adder.
                        state_next     = HOLD;
                        out_valid_next = 1'b1;
                        out_data_next  = acc_sum;
                        out_sat_next   = sat_reg | sat_hit;
                    end
                end
            end

            HOLD: begin
                if (abort) begin
                    state_next     = IDLE;
                    acc_next       = '0;
                    cnt_next       = '0;
                    sat_next       = 1'b0;
                    out_valid_next = 1'b0;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (start) begin
                        // Back-to-back window without an idle bubble.
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        sat_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            sat_reg       <= sat_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule
